// File: rtl/sensor_seq_pkg.sv
// Shared types and default tables for the sensor poll sequencer.
// Default slave map: accel at 8'h32, magnetometer at 8'h3C.
package sensor_seq_pkg;

    localparam int ADDR_W = 8;
    localparam int VAL_W  = 8;
    localparam int IDX_W  = 4;
    localparam int ENT_W  = 24;

    localparam logic [7:0] SLV_ACCEL    = 8'h32;
    localparam logic [7:0] SLV_MAG      = 8'h3C;
    localparam logic [7:0] ACC_CTRL_REG = 8'h20;
    localparam logic [7:0] ACC_CTRL_VAL = 8'h37;
    localparam logic [7:0] MAG_MODE_REG = 8'h02;
    localparam logic [7:0] MAG_MODE_VAL = 8'h00;

    // ch0 / entry0 in the LSBs
    localparam logic [47:0] DEF_CH_SLAVE = {SLV_MAG, SLV_MAG, SLV_MAG, SLV_ACCEL, SLV_ACCEL, SLV_ACCEL};
    localparam logic [47:0] DEF_CH_REG   = {8'h05, 8'h07, 8'h03, 8'hAC, 8'hAA, 8'hA8};
    localparam logic [47:0] DEF_INIT_TBL = {SLV_MAG, MAG_MODE_REG, MAG_MODE_VAL,
                                            SLV_ACCEL, ACC_CTRL_REG, ACC_CTRL_VAL};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_ISS,
        ST_INIT_WAIT,
        ST_ARMED,
        ST_RD_ISS,
        ST_RD_WAIT,
        ST_COMMIT
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] slave;
        logic [ADDR_W-1:0] regad;
        logic [VAL_W-1:0]  value;
        logic              rd;
    } txn_fields_t;

endpackage

// File: rtl/sensor_seq_table.sv
// Combinational lookup: index -> transaction fields, from the channel
// read list (rd_sel=1) or the init write table (rd_sel=0).
module sensor_seq_table
    import sensor_seq_pkg::*;
#(
    parameter int NUM_CH   = 6,
    parameter int NUM_INIT = 2,
    parameter logic [NUM_CH*8-1:0] CH_SLAVE = DEF_CH_SLAVE,
    parameter logic [NUM_CH*8-1:0] CH_REG   = DEF_CH_REG,
    parameter logic [((NUM_INIT > 0) ? NUM_INIT : 1)*ENT_W-1:0] INIT_TBL = DEF_INIT_TBL
) (
    input  logic             rd_sel,
    input  logic [IDX_W-1:0] idx,
    output txn_fields_t      ent
);

    always_comb begin
        ent = '0;
        if (rd_sel) begin
            if (int'(idx) < NUM_CH) begin
                ent.slave = CH_SLAVE[int'(idx)*8 +: 8];
                ent.regad = CH_REG[int'(idx)*8 +: 8];
                ent.rd    = 1'b1;
            end
        end else if (int'(idx) < NUM_INIT) begin
            {ent.slave, ent.regad, ent.value} = INIT_TBL[int'(idx)*ENT_W +: ENT_W];
        end
    end

endmodule

// File: rtl/sensor_poll_sequencer.sv
// Replays an init write table on start, then reads NUM_CH channels per frame
// request and commits them as one snapshot. Optional watchdog: SEQ_TIMEOUT_EN.
module sensor_poll_sequencer
    import sensor_seq_pkg::*;
#(
    parameter int NUM_CH   = 6,
    parameter int NUM_INIT = 2,
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 32,
    parameter logic [NUM_CH*8-1:0] CH_SLAVE = DEF_CH_SLAVE,
    parameter logic [NUM_CH*8-1:0] CH_REG   = DEF_CH_REG,
    parameter logic [((NUM_INIT > 0) ? NUM_INIT : 1)*ENT_W-1:0] INIT_TBL = DEF_INIT_TBL,
    parameter int TMO_CYC  = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    frame_req,
    output logic                    txn_req,
    input  logic                    txn_ack,
    output logic                    txn_rd,
    output logic [7:0]              txn_slave,
    output logic [7:0]              txn_reg,
    output logic [7:0]              txn_wdata,
    input  logic                    txn_done,
    input  logic [DATA_W-1:0]       txn_rdata,
    output logic [NUM_CH*OUT_W-1:0] ch_data,
    output logic                    frame_valid,
    output logic [15:0]             frame_cnt,
    output logic [7:0]              overrun_cnt,
    output logic                    armed,
    output logic                    busy,
    output logic                    err
);

    if (NUM_CH < 1 || NUM_CH > 16 || NUM_INIT < 0 || NUM_INIT > 8 ||
        OUT_W < DATA_W || TMO_CYC < 1) begin : g_param_chk
        $error("sensor_poll_sequencer: parameter out of range");
    end

    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_INIT - 1);

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            pending_q, pending_d;
    logic                            restart_q, restart_d;
    logic [NUM_CH-1:0][OUT_W-1:0]    shadow_q, shadow_d;
    logic [NUM_CH-1:0][OUT_W-1:0]    ch_data_q, ch_data_d;
    logic                            frame_valid_q, frame_valid_d;
    logic [15:0]                     frame_cnt_q, frame_cnt_d;
    logic [7:0]                      overrun_q, overrun_d;
    logic                            armed_q, armed_d;
    logic                            busy_w, restart_now, do_init, ovr_inc;
    txn_fields_t                     ent;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             in_txn;
`endif

    sensor_seq_table #(
        .NUM_CH   (NUM_CH),
        .NUM_INIT (NUM_INIT),
        .CH_SLAVE (CH_SLAVE),
        .CH_REG   (CH_REG),
        .INIT_TBL (INIT_TBL)
    ) u_table (
        .rd_sel (state_q inside {ST_RD_ISS, ST_RD_WAIT}),
        .idx    (idx_q),
        .ent    (ent)
    );

    assign busy_w = !(state_q inside {ST_IDLE, ST_ARMED});

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        restart_d     = restart_q;
        shadow_d      = shadow_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        armed_d       = armed_q;
        do_init       = 1'b0;
        ovr_inc       = 1'b0;
        restart_now   = restart_q | start;

        // A start while busy is deferred until the in-flight transaction completes.
        if (busy_w) begin
            if (start) begin
                restart_d = 1'b1;
                pending_d = 1'b0;
                ovr_inc   = frame_req;
            end else if (frame_req) begin
                if (pending_q) ovr_inc   = 1'b1;
                else           pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: if (start) do_init = 1'b1;
            ST_ARMED: begin
                if (start) begin
                    do_init = 1'b1;
                    ovr_inc = frame_req;
                end else if (frame_req || pending_q) begin
                    state_d   = ST_RD_ISS;
                    idx_d     = '0;
                    pending_d = frame_req && pending_q;
                end
            end
            ST_INIT_ISS: if (txn_ack) state_d = ST_INIT_WAIT;
            ST_RD_ISS:   if (txn_ack) state_d = ST_RD_WAIT;
            ST_INIT_WAIT: begin
                if (txn_done) begin
                    if (restart_now) begin
                        do_init = 1'b1;
                    end else if (idx_q == LAST_INIT) begin
                        state_d = ST_ARMED;
                        armed_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_INIT_ISS;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (txn_done) begin
                    shadow_d[idx_q] = OUT_W'($signed(txn_rdata));
                    if (restart_now) begin
                        do_init = 1'b1;
                    end else if (idx_q == LAST_CH) begin
                        state_d = ST_COMMIT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD_ISS;
                    end
                end
            end
            ST_COMMIT: begin
                ch_data_d     = shadow_q;
                frame_valid_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 16'd1;
                if (restart_now) do_init = 1'b1;
                else             state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_init) begin
            idx_d     = '0;
            pending_d = 1'b0;
            restart_d = 1'b0;
            if (NUM_INIT == 0) begin
                state_d = ST_ARMED;
                armed_d = 1'b1;
            end else begin
                state_d = ST_INIT_ISS;
                armed_d = 1'b0;
            end
        end

`ifdef SEQ_TIMEOUT_EN
        in_txn = state_q inside {ST_INIT_ISS, ST_INIT_WAIT, ST_RD_ISS, ST_RD_WAIT};
        err_d  = start ? 1'b0 : err_q;
        tmo_d  = '0;
        // Counter restarts on every state entry, so the limit applies per ack/done wait.
        if (in_txn && state_d == state_q) begin
            if (tmo_q == TMO_LAST) begin
                err_d     = 1'b1;
                shadow_d  = '0;
                idx_d     = '0;
                restart_d = 1'b0;
                if (state_q inside {ST_INIT_ISS, ST_INIT_WAIT}) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                end else begin
                    state_d = ST_ARMED;
                end
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif

        overrun_d = (ovr_inc && overrun_q != 8'hFF) ? overrun_q + 8'd1 : overrun_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            restart_q     <= 1'b0;
            shadow_q      <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= '0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            restart_q     <= restart_d;
            shadow_q      <= shadow_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_q     <= overrun_d;
            armed_q       <= armed_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Request is a decode of the state flop, so async reset drops it immediately.
    assign txn_req     = (state_q == ST_INIT_ISS) || (state_q == ST_RD_ISS);
    assign txn_rd      = ent.rd;
    assign txn_slave   = ent.slave;
    assign txn_reg     = ent.regad;
    assign txn_wdata   = ent.value;
    assign ch_data     = ch_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_q;
    assign armed       = armed_q;
    assign busy        = busy_w;

endmodule
